riscv_pipeline_top: RTL and testbench

//  Top level of a 5-stage in-order RV32I-subset core: IF, ID, EX, MEM, WB.

---
 rtl/riscv_pipeline_top.sv | 249 ++++++++++++++++++++++++
 tb/tb_riscv_pipeline_top.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/riscv_pipeline_top.sv
// riscv_pipeline_top: 5-stage in-order RV32I-subset core (IF/ID/EX/MEM/WB) with internal
// instruction ROM, register file and data RAM. No forwarding, no stalls; software spaces hazards.
package riscv_pkg;
   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
   typedef struct packed {
      logic    reg_write;
      logic    mem_write;
      logic    mem_read;
      logic    alu_src;
      alu_op_e alu_op;
   } ctrl_t;
endpackage

// Word-addressed memory: combinational read, synchronous write, no reset so preloads survive.
module riscv_wordmem #(parameter int WORDS = 256) (
   input  logic        clk_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o
);
   localparam int AW = $clog2(WORDS);
   logic [31:0] memory [0:WORDS-1];
   logic        unused_addr;

   assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
   assign rdata_o     = memory[addr_i[AW+1:2]];

   always_ff @(posedge clk_i) begin
      if (we_i) memory[addr_i[AW+1:2]] <= wdata_i;
   end
endmodule

module riscv_regfile (
   input  logic        clk_i,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr1_i,
   input  logic [4:0]  raddr2_i,
   output logic [31:0] rdata1_o,
   output logic [31:0] rdata2_o
);
   logic [31:0] regfile [0:31];

   assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regfile[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regfile[raddr2_i];

   // Falling-edge write lets a decode read in the same cycle see the new value.
   always_ff @(negedge clk_i) begin
      if (we_i && (waddr_i != 5'd0)) regfile[waddr_i] <= wdata_i;
   end
endmodule

module riscv_fetch #(parameter int IMEM_WORDS = 256) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic [31:0] instr_o
);
   logic [31:0] pc_q, pc_d;

   assign pc_d = pc_q + 32'd4;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pc_q <= 32'd0;
      else         pc_q <= pc_d;
   end

   riscv_wordmem #(.WORDS(IMEM_WORDS)) IM (
      .clk_i(clk_i), .we_i(1'b0), .addr_i(pc_q), .wdata_i(32'd0), .rdata_o(instr_o)
   );
endmodule

module riscv_decode
   import riscv_pkg::*;
(
   input  logic        clk_i,
   input  logic [31:0] instr_i,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   output logic [31:0] rs1_val_o,
   output logic [31:0] rs2_val_o,
   output logic [31:0] imm_o,
   output logic [4:0]  rd_o,
   output ctrl_t       ctrl_o
);
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic       is_store, f3_ok;
   alu_op_e    f3_op;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];
   assign rd_o   = instr_i[11:7];
   assign imm_o  = is_store ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]}
                            : {{20{instr_i[31]}}, instr_i[31:20]};

   always_comb begin
      f3_op = ALU_ADD;
      f3_ok = 1'b1;
      case (funct3)
         3'b000:  f3_op = ALU_ADD;
         3'b111:  f3_op = ALU_AND;
         3'b110:  f3_op = ALU_OR;
         3'b010:  f3_op = ALU_SLT;
         default: f3_ok = 1'b0;
      endcase
   end

   // Anything not recognised leaves ctrl_o all-zero, i.e. a bubble.
   always_comb begin
      ctrl_o   = '0;
      is_store = 1'b0;
      case (opcode)
         7'b0110011: begin
            ctrl_o.reg_write = f3_ok && ((funct3 != 3'b000) || (funct7 == 7'b0000000) ||
                                         (funct7 == 7'b0100000));
            ctrl_o.alu_op    = ((funct3 == 3'b000) && (funct7 == 7'b0100000)) ? ALU_SUB : f3_op;
         end
         7'b0010011: begin
            ctrl_o.reg_write = f3_ok;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.alu_op    = f3_op;
         end
         7'b0000011: begin
            ctrl_o.reg_write = (funct3 == 3'b010);
            ctrl_o.mem_read  = (funct3 == 3'b010);
            ctrl_o.alu_src   = 1'b1;
         end
         7'b0100011: begin
            ctrl_o.mem_write = (funct3 == 3'b010);
            ctrl_o.alu_src   = 1'b1;
            is_store         = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

   riscv_regfile RF (
      .clk_i(clk_i), .we_i(wb_we_i), .waddr_i(wb_rd_i), .wdata_i(wb_data_i),
      .raddr1_i(instr_i[19:15]), .raddr2_i(instr_i[24:20]),
      .rdata1_o(rs1_val_o), .rdata2_o(rs2_val_o)
   );
endmodule

module riscv_mem #(parameter int DMEM_WORDS = 256) (
   input  logic        clk_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o
);
   riscv_wordmem #(.WORDS(DMEM_WORDS)) DM (
      .clk_i(clk_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o)
   );
endmodule

module riscv_pipeline_top
   import riscv_pkg::*;
#(
   parameter int IMEM_WORDS = 256,
   parameter int DMEM_WORDS = 256
) (
   input logic CLK,
   input logic RST_N
);
   logic [31:0] if_instr, ifid_instr_q;
   logic [31:0] id_rs1, id_rs2, id_imm;
   logic [4:0]  id_rd;
   ctrl_t       id_ctrl;
   logic [31:0] idex_rs1_q, idex_rs2_q, idex_imm_q;
   logic [4:0]  idex_rd_q;
   ctrl_t       idex_ctrl_q;
   logic [31:0] ex_op_b, ex_result_d;
   logic [31:0] exmem_result_q, exmem_store_q;
   logic [4:0]  exmem_rd_q;
   logic        exmem_reg_write_q, exmem_mem_write_q, exmem_mem_read_q;
   logic [31:0] mem_rdata, memwb_data_d, memwb_data_q;
   logic [4:0]  memwb_rd_q;
   logic        memwb_reg_write_q;

   riscv_fetch #(.IMEM_WORDS(IMEM_WORDS)) F (.clk_i(CLK), .rst_ni(RST_N), .instr_o(if_instr));

   riscv_decode D (
      .clk_i(CLK), .instr_i(ifid_instr_q),
      .wb_we_i(memwb_reg_write_q), .wb_rd_i(memwb_rd_q), .wb_data_i(memwb_data_q),
      .rs1_val_o(id_rs1), .rs2_val_o(id_rs2), .imm_o(id_imm), .rd_o(id_rd), .ctrl_o(id_ctrl)
   );

   assign ex_op_b = idex_ctrl_q.alu_src ? idex_imm_q : idex_rs2_q;

   always_comb begin
      ex_result_d = 32'd0;
      case (idex_ctrl_q.alu_op)
         ALU_ADD: ex_result_d = idex_rs1_q + ex_op_b;
         ALU_SUB: ex_result_d = idex_rs1_q - ex_op_b;
         ALU_AND: ex_result_d = idex_rs1_q & ex_op_b;
         ALU_OR:  ex_result_d = idex_rs1_q | ex_op_b;
         ALU_SLT: ex_result_d = {31'd0, ($signed(idex_rs1_q) < $signed(ex_op_b))};
         default: ex_result_d = 32'd0;
      endcase
   end

   riscv_mem #(.DMEM_WORDS(DMEM_WORDS)) M (
      .clk_i(CLK), .we_i(exmem_mem_write_q), .addr_i(exmem_result_q),
      .wdata_i(exmem_store_q), .rdata_o(mem_rdata)
   );

   assign memwb_data_d = exmem_mem_read_q ? mem_rdata : exmem_result_q;

   // Reset turns every stage into a bubble so nothing in flight can write RF or DM.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ifid_instr_q      <= 32'd0;
         idex_rs1_q        <= 32'd0;
         idex_rs2_q        <= 32'd0;
         idex_imm_q        <= 32'd0;
         idex_rd_q         <= 5'd0;
         idex_ctrl_q       <= '0;
         exmem_result_q    <= 32'd0;
         exmem_store_q     <= 32'd0;
         exmem_rd_q        <= 5'd0;
         exmem_reg_write_q <= 1'b0;
         exmem_mem_write_q <= 1'b0;
         exmem_mem_read_q  <= 1'b0;
         memwb_data_q      <= 32'd0;
         memwb_rd_q        <= 5'd0;
         memwb_reg_write_q <= 1'b0;
      end else begin
         ifid_instr_q      <= if_instr;
         idex_rs1_q        <= id_rs1;
         idex_rs2_q        <= id_rs2;
         idex_imm_q        <= id_imm;
         idex_rd_q         <= id_rd;
         idex_ctrl_q       <= id_ctrl;
         exmem_result_q    <= ex_result_d;
         exmem_store_q     <= idex_rs2_q;
         exmem_rd_q        <= idex_rd_q;
         exmem_reg_write_q <= idex_ctrl_q.reg_write;
         exmem_mem_write_q <= idex_ctrl_q.mem_write;
         exmem_mem_read_q  <= idex_ctrl_q.mem_read;
         memwb_data_q      <= memwb_data_d;
         memwb_rd_q        <= exmem_rd_q;
         memwb_reg_write_q <= exmem_reg_write_q;
      end
   end
endmodule

// File: tb/tb_riscv_pipeline_top.sv
// Directed bench for riscv_pipeline_top: backdoor-loaded programs, hand-computed register/memory results.
module tb_riscv_pipeline_top;
   logic CLK   = 1'b0;
   logic RST_N = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   riscv_pipeline_top dut (.CLK(CLK), .RST_N(RST_N));

   always #50 CLK = ~CLK;

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   localparam logic [6:0] OPI = 7'b0010011;

   initial begin
      // ---------------- phase 1: main program ----------------
      #5 RST_N = 1'b0;
      for (int i = 0; i < 256; i++) begin
         dut.F.IM.memory[i] = 32'd0;
         dut.M.DM.memory[i] = 32'hDEAD_0000 + i;
      end
      for (int i = 0; i < 32; i++) dut.D.RF.regfile[i] = i;

      dut.F.IM.memory[0]  = enc_r(7'h00, 5'd2,  5'd1,  3'b000, 5'd5);   // ADD  x5,x1,x2
      dut.F.IM.memory[1]  = enc_r(7'h20, 5'd4,  5'd3,  3'b000, 5'd6);   // SUB  x6,x3,x4
      dut.F.IM.memory[2]  = enc_r(7'h00, 5'd8,  5'd9,  3'b111, 5'd7);   // AND  x7,x9,x8
      dut.F.IM.memory[3]  = enc_r(7'h00, 5'd12, 5'd13, 3'b110, 5'd10);  // OR   x10,x13,x12
      dut.F.IM.memory[4]  = enc_r(7'h00, 5'd14, 5'd15, 3'b010, 5'd11);  // SLT  x11,x15,x14
      dut.F.IM.memory[5]  = enc_i(12'd20,  5'd0, 3'b000, 5'd16, OPI);   // ADDI x16,x0,20
      dut.F.IM.memory[6]  = enc_i(12'd15,  5'd0, 3'b111, 5'd17, OPI);   // ANDI x17,x0,15
      dut.F.IM.memory[7]  = enc_i(12'd31,  5'd0, 3'b110, 5'd18, OPI);   // ORI  x18,x0,31
      dut.F.IM.memory[8]  = enc_i(12'd1,   5'd0, 3'b010, 5'd19, OPI);   // SLTI x19,x0,1
      dut.F.IM.memory[9]  = enc_sw(12'd0, 5'd2, 5'd20);                 // SW   x2,0(x20)
      dut.F.IM.memory[10] = enc_i(12'd0, 5'd20, 3'b010, 5'd21, 7'b0000011); // LW x21,0(x20)
      dut.F.IM.memory[11] = enc_i(12'd99,  5'd0, 3'b000, 5'd22, OPI);   // ADDI x22,x0,99
      dut.F.IM.memory[12] = enc_i(12'd123, 5'd0, 3'b000, 5'd23, OPI);   // ADDI x23,x0,123
      dut.F.IM.memory[13] = enc_i(12'd5,   5'd0, 3'b000, 5'd0,  OPI);   // ADDI x0,x0,5
      dut.F.IM.memory[14] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd25, OPI);   // ADDI x25,x0,-1
      dut.F.IM.memory[18] = enc_r(7'h00, 5'd1, 5'd25, 3'b010, 5'd26);   // SLT  x26,x25,x1
      dut.F.IM.memory[19] = enc_sw(12'hFFC, 5'd3, 5'd20);               // SW   x3,-4(x20)
      dut.F.IM.memory[20] = enc_i(12'd4, 5'd20, 3'b010, 5'd27, 7'b0000011); // LW x27,4(x20)
      dut.F.IM.memory[21] = enc_r(7'h00, 5'd25, 5'd25, 3'b000, 5'd28);  // ADD  x28,x25,x25
      dut.F.IM.memory[22] = enc_i(12'h123, 5'd0, 3'b000, 5'd29, 7'b0110111); // unsupported
      dut.F.IM.memory[23] = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd30);    // f7 not ADD/SUB

      tick();
      tick();
      check("reset_pc", dut.F.pc_q, 32'd0);
      check("reset_wb_bubble", {31'd0, dut.memwb_reg_write_q}, 32'd0);
      check("reset_mem_bubble", {31'd0, dut.exmem_mem_write_q}, 32'd0);
      RST_N = 1'b1;

      tick();
      check("pc_after_first_edge", dut.F.pc_q, 32'd4);
      repeat (3) tick();
      check("x5_before_wb", dut.D.RF.regfile[5], 32'd5);
      @(negedge CLK);
      #1;
      check("x5_at_wb_fall", dut.D.RF.regfile[5], 32'd3);
      repeat (36) tick();

      check("add_x5",       dut.D.RF.regfile[5],  32'd3);
      check("sub_x6",       dut.D.RF.regfile[6],  32'hFFFF_FFFF);
      check("and_x7",       dut.D.RF.regfile[7],  32'd8);
      check("or_x10",       dut.D.RF.regfile[10], 32'd13);
      check("slt_x11",      dut.D.RF.regfile[11], 32'd0);
      check("addi_x16",     dut.D.RF.regfile[16], 32'd20);
      check("andi_x17",     dut.D.RF.regfile[17], 32'd0);
      check("ori_x18",      dut.D.RF.regfile[18], 32'd31);
      check("slti_x19",     dut.D.RF.regfile[19], 32'd1);
      check("sw_dm5",       dut.M.DM.memory[5],   32'd2);
      check("lw_x21",       dut.D.RF.regfile[21], 32'd2);
      check("addi_x22",     dut.D.RF.regfile[22], 32'd99);
      check("addi_x23",     dut.D.RF.regfile[23], 32'd123);
      check("x0_zero",      dut.D.RF.regfile[0],  32'd0);
      check("x24_preload",  dut.D.RF.regfile[24], 32'd24);
      check("addi_neg_x25", dut.D.RF.regfile[25], 32'hFFFF_FFFF);
      check("slt_signed_x26", dut.D.RF.regfile[26], 32'd1);
      check("sw_neg_off_dm4", dut.M.DM.memory[4], 32'd3);
      check("lw_x27",       dut.D.RF.regfile[27], 32'hDEAD_0006);
      check("add_wrap_x28", dut.D.RF.regfile[28], 32'hFFFF_FFFE);
      check("bad_opcode_x29", dut.D.RF.regfile[29], 32'd29);
      check("bad_funct7_x30", dut.D.RF.regfile[30], 32'd30);
      check("dm7_untouched", dut.M.DM.memory[7],  32'hDEAD_0007);

      // ---------------- phase 2: reset mid-program ----------------
      RST_N = 1'b0;
      for (int i = 0; i < 256; i++) dut.F.IM.memory[i] = 32'd0;
      dut.F.IM.memory[0] = enc_i(12'd77, 5'd0, 3'b000, 5'd5,  OPI);     // ADDI x5,x0,77
      dut.F.IM.memory[1] = enc_sw(12'd28, 5'd1, 5'd0);                  // SW   x1,28(x0)
      dut.F.IM.memory[2] = enc_i(12'd55, 5'd0, 3'b000, 5'd12, OPI);     // ADDI x12,x0,55
      dut.F.IM.memory[3] = enc_i(12'd66, 5'd0, 3'b000, 5'd13, OPI);     // ADDI x13,x0,66
      dut.F.IM.memory[4] = enc_sw(12'd32, 5'd1, 5'd0);                  // SW   x1,32(x0)
      dut.F.IM.memory[5] = enc_i(12'd44, 5'd0, 3'b000, 5'd14, OPI);     // ADDI x14,x0,44
      tick();
      tick();
      RST_N = 1'b1;
      repeat (5) tick();
      RST_N = 1'b0;
      tick();
      tick();

      check("rst2_pc",          dut.F.pc_q,           32'd0);
      check("rst2_x5_done",     dut.D.RF.regfile[5],  32'd77);
      check("rst2_dm7_done",    dut.M.DM.memory[7],   32'd1);
      check("rst2_x12_squashed", dut.D.RF.regfile[12], 32'd12);
      check("rst2_x13_squashed", dut.D.RF.regfile[13], 32'd13);
      check("rst2_dm8_squashed", dut.M.DM.memory[8],   32'hDEAD_0008);
      check("rst2_x14_squashed", dut.D.RF.regfile[14], 32'd14);
      check("rst2_x22_kept",    dut.D.RF.regfile[22], 32'd99);

      RST_N = 1'b1;
      tick();
      tick();
      check("restart_pc", dut.F.pc_q, 32'd8);
      repeat (12) tick();
      check("restart_x12", dut.D.RF.regfile[12], 32'd55);
      check("restart_x13", dut.D.RF.regfile[13], 32'd66);
      check("restart_x14", dut.D.RF.regfile[14], 32'd44);
      check("restart_dm8", dut.M.DM.memory[8],   32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
